// File: rtl/overlay_pkg.sv
// Shared overlay definitions: colour constants, emblem FSM states, default shield rows.
// No logic, no latency, no flow control.
// Imported by every overlay block that needs the colour key or the shield geometry.
package overlay_pkg;

    localparam logic [5:0] TRANSPARENT = 6'b100001;
    localparam logic [5:0] BLACK       = 6'b000000;
    localparam logic [5:0] GOLD        = 6'b111000;
    localparam logic [5:0] RED         = 6'b110000;
    localparam logic [5:0] WHITE       = 6'b111111;

    localparam int SHIELD_TOP_DEF = 144;
    localparam int SHIELD_BOT_DEF = 320;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REVEAL = 2'd1,
        ST_HOLD   = 2'd2,
        ST_WIPE   = 2'd3
    } emblem_state_t;

    function automatic logic is_keyed(input logic [5:0] colour);
        return colour == TRANSPARENT;
    endfunction

endpackage

// File: rtl/emblem_reveal_ctrl_frame_timer.sv
// Frame counter: counts tick pulses while enabled, clear has priority, tc at TERMINAL.
// Latency: count updates one clock after the tick; tc is combinational from the count.
// No backpressure; the count stops at TERMINAL until cleared.
module frame_timer #(
    parameter int WIDTH    = 7,
    parameter int TERMINAL = 119
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic tick,
    output logic tc
);

    logic [WIDTH-1:0] cnt;

    assign tc = (cnt == WIDTH'(TERMINAL));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && tick && !tc) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/emblem_reveal_ctrl.sv
// Emblem reveal/hold/wipe controller and pixel compositor; EMBLEM_AUTO_REPEAT_EN re-arms after idle.
// Latency: rgb_out is exactly 1 clock behind the pixel inputs; state moves on frame_start.
// No backpressure: pixel stream is free-running, control pulses are single-clock.
module emblem_reveal_ctrl
    import overlay_pkg::*;
#(
    parameter int REVEAL_STEP = 4,
    parameter int HOLD_FRAMES = 120,
    parameter int SHIELD_TOP  = SHIELD_TOP_DEF,
    parameter int SHIELD_BOT  = SHIELD_BOT_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       active,
    input  logic       frame_start,
    input  logic       trigger,
    input  logic       hide,
    input  logic [5:0] emblem_rgb,
    input  logic [5:0] bg_rgb,
    output logic [5:0] rgb_out,
    output logic       busy,
    output logic [1:0] state
);

    localparam int         HW     = $clog2(HOLD_FRAMES + 1);
    localparam logic [9:0] TOP_L  = 10'(SHIELD_TOP);
    localparam logic [9:0] BOT_L  = 10'(SHIELD_BOT);
    localparam logic [9:0] STEP_L = 10'(REVEAL_STEP);

    emblem_state_t st, st_nxt;
    logic [9:0]    reveal_line, line_nxt;
    logic [5:0]    pix_nxt;
    logic          tmr_clr, tmr_en, tmr_tc;
    logic          unused_x;

    // The wipe is purely row-based, so the column carries no information here.
    assign unused_x = ^x;

`ifdef EMBLEM_AUTO_REPEAT_EN
    logic arm;

    always_ff @(posedge clk) begin
        if (!rst_n || hide) begin
            arm <= 1'b0;
        end else if (st == ST_WIPE && st_nxt == ST_IDLE) begin
            arm <= 1'b1;
        end
    end

    assign tmr_en = (st == ST_HOLD) || (st == ST_IDLE && arm);
`else
    assign tmr_en = (st == ST_HOLD);
`endif

    // One timer serves both the hold period and the idle re-arm period.
    assign tmr_clr = hide || (st_nxt != st);

    frame_timer #(
        .WIDTH    (HW),
        .TERMINAL (HOLD_FRAMES - 1)
    ) u_frame_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tmr_clr),
        .en    (tmr_en),
        .tick  (frame_start),
        .tc    (tmr_tc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st          <= ST_IDLE;
            reveal_line <= TOP_L;
        end else begin
            st          <= st_nxt;
            reveal_line <= line_nxt;
        end
    end

    // Limits are compared before stepping so the 10-bit line never wraps.
    always_comb begin
        st_nxt   = st;
        line_nxt = reveal_line;
        if (hide) begin
            st_nxt   = ST_IDLE;
            line_nxt = TOP_L;
        end else begin
            unique case (st)
                ST_IDLE: begin
                    if (trigger) begin
                        st_nxt   = ST_REVEAL;
                        line_nxt = TOP_L;
                    end
`ifdef EMBLEM_AUTO_REPEAT_EN
                    else if (arm && frame_start && tmr_tc) begin
                        st_nxt   = ST_REVEAL;
                        line_nxt = TOP_L;
                    end
`endif
                end
                ST_REVEAL: begin
                    if (frame_start) begin
                        if (reveal_line >= BOT_L - STEP_L) begin
                            line_nxt = BOT_L;
                            st_nxt   = ST_HOLD;
                        end else begin
                            line_nxt = reveal_line + STEP_L;
                        end
                    end
                end
                ST_HOLD: begin
                    if (frame_start && tmr_tc) begin
                        st_nxt = ST_WIPE;
                    end
                end
                ST_WIPE: begin
                    if (frame_start) begin
                        if (reveal_line <= TOP_L + STEP_L) begin
                            line_nxt = TOP_L;
                            st_nxt   = ST_IDLE;
                        end else begin
                            line_nxt = reveal_line - STEP_L;
                        end
                    end
                end
                default: st_nxt = ST_IDLE;
            endcase
        end
    end

    // hide also blanks the pixel sampled in its own clock, so nothing leaks past it.
    always_comb begin
        busy    = (st != ST_IDLE);
        state   = st;
        pix_nxt = BLACK;
        if (active && st != ST_IDLE && !hide && y < reveal_line && !is_keyed(emblem_rgb)) begin
            pix_nxt = emblem_rgb;
        end else if (active) begin
            pix_nxt = bg_rgb;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rgb_out <= BLACK;
        end else begin
            rgb_out <= pix_nxt;
        end
    end

endmodule
